// File: rtl/tacho_pkg.sv
// tacho_pkg -- shared definitions for the multi-channel tachometer block.
// Holds the CSR register offsets, STATUS bit positions, parameter legality
// limits and the address decoder used by tacho_multi and its bench.
package tacho_pkg;

    // Register offsets relative to BASE_ADDR. CNT_LO[n] sits at
    // OFF_CNT_BASE + 2n and CNT_HI[n] directly above it.
    localparam int OFF_CTRL     = 0;
    localparam int OFF_STATUS   = 1;
    localparam int OFF_CNT_BASE = 2;

    // STATUS layout: OVF[n] at bit OVF_LSB+n, VALID[n] at bit VALID_LSB+n.
    localparam int STATUS_OVF_LSB   = 0;
    localparam int STATUS_VALID_LSB = 4;

    // Legal parameter ranges.
    localparam int NUM_CH_MIN   = 1;
    localparam int NUM_CH_MAX   = 4;
    localparam int CNT_W_MIN    = 9;
    localparam int CNT_W_MAX    = 16;
    localparam int FILT_LEN_MIN = 1;
    localparam int FILT_LEN_MAX = 8;
    localparam int ADDR_SPAN    = 32;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_STATUS,
        REG_CNT_LO,
        REG_CNT_HI
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [1:0] ch;
    } reg_sel_t;

    // Maps a CSR byte address onto a register kind and channel index.
    // The offset is computed as a signed int so addresses below the base
    // come out negative instead of wrapping onto a mapped register.
    function automatic reg_sel_t decode(input logic [4:0] addr,
                                        input logic [4:0] base,
                                        input int         num_ch);
        reg_sel_t sel;
        int       off;
        sel.kind = REG_NONE;
        sel.ch   = '0;
        off      = int'(addr) - int'(base);
        if (off == OFF_CTRL) begin
            sel.kind = REG_CTRL;
        end else if (off == OFF_STATUS) begin
            sel.kind = REG_STATUS;
        end else if (off >= OFF_CNT_BASE && off < OFF_CNT_BASE + 2 * num_ch) begin
            sel.kind = off[0] ? REG_CNT_HI : REG_CNT_LO;
            sel.ch   = 2'((off - OFF_CNT_BASE) / 2);
        end
        return sel;
    endfunction

    // CTRL bits that exist for a given channel count.
    function automatic logic [7:0] ctrl_mask(input int num_ch);
        return 8'((1 << num_ch) - 1);
    endfunction

endpackage

// File: rtl/tacho_multi_channel.sv
// tacho_channel -- one tachometer channel.
// tacho_in -> 2-flop synchroniser -> run-length glitch filter -> rising-edge
// counter (saturating) -> capture register on ce_1s, plus the CNT_HI shadow
// and the sticky OVF / VALID flags.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : channel enable (CTRL bit)
//   tacho_in    : asynchronous tacho input
//   ce_1s       : gate-window strobe
//   lo_rd       : CSR read of this channel's CNT_LO
//   ovf_clr     : write-1-to-clear of OVF
//   capture     : count of the last completed window
//   shadow      : capture[CNT_W-1:8] latched on lo_rd, zero-extended
//   ovf, valid  : sticky overflow, fresh-capture flag
module tacho_channel #(
    parameter int CNT_W    = 12,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tacho_in,
    input  logic             ce_1s,
    input  logic             lo_rd,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] capture,
    output logic [7:0]       shadow,
    output logic             ovf,
    output logic             valid
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d_q;
    logic [RUN_W-1:0] run_q;
    logic [CNT_W-1:0] live_q;

    logic             level_nxt, level_d_nxt;
    logic [RUN_W-1:0] run_nxt;
    logic [CNT_W-1:0] live_nxt, capture_nxt;
    logic [7:0]       shadow_nxt;
    logic             ovf_nxt, valid_nxt, ovf_set, rise;

    // Filter: count consecutive synchronised samples that disagree with the
    // current level; flip only when the run reaches FILT_LEN.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        level_nxt = level_q;
        run_nxt   = run_q;
        if (!en) begin
            level_nxt = 1'b0;
            run_nxt   = '0;
        end else if (sync_q[1] == level_q) begin
            run_nxt = '0;
        end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
            level_nxt = sync_q[1];
            run_nxt   = '0;
        end else begin
            run_nxt = run_q + 1'b1;
        end
    end

    // The edge is taken from the registered level, which puts the count one
    // cycle after the filter flips: 2 sync + FILT_LEN filter + 1 = 3+FILT_LEN.
    assign rise        = level_q & ~level_d_q;
    assign level_d_nxt = en & level_q;

    always_comb begin
        live_nxt    = live_q;
        capture_nxt = capture;
        ovf_set     = 1'b0;
        if (!en) begin
            live_nxt = '0;
        end
        if (ce_1s) begin
            capture_nxt = en ? live_q : '0;
            // An edge on the window boundary belongs to the new window.
            live_nxt    = (en && rise) ? CNT_W'(1) : '0;
        end else if (en && rise) begin
            if (live_q == {CNT_W{1'b1}}) begin
                ovf_set = 1'b1;
            end else begin
                live_nxt = live_q + 1'b1;
            end
        end
    end

    // Sets take priority over clears for both sticky flags.
    assign ovf_nxt    = ovf_set | (ovf & ~ovf_clr);
    assign valid_nxt  = (ce_1s & en) | (valid & ~lo_rd);
    assign shadow_nxt = lo_rd ? 8'(capture >> 8) : shadow;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            run_q     <= '0;
            live_q    <= '0;
            capture   <= '0;
            shadow    <= '0;
            ovf       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], tacho_in};
            level_q   <= level_nxt;
            level_d_q <= level_d_nxt;
            run_q     <= run_nxt;
            live_q    <= live_nxt;
            capture   <= capture_nxt;
            shadow    <= shadow_nxt;
            ovf       <= ovf_nxt;
            valid     <= valid_nxt;
        end
    end

endmodule

// File: rtl/tacho_multi.sv
// tacho_multi -- multi-channel tachometer with a byte-wide CSR port.
// Counts filtered rising edges of each tacho input per ce_1s gate window.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   csr_a, csr_di      : CSR byte address, write data
//   csr_we, csr_re     : single-cycle write / read strobes
//   csr_do             : combinational read data (0 for unmapped addresses)
//   ce_1s              : gate-window strobe
//   tacho_in[NUM_CH]   : asynchronous tacho inputs, bit n = channel n
// Registers (offset from BASE_ADDR): 0 CTRL, 1 STATUS, 2+2n CNT_LO[n],
// 3+2n CNT_HI[n].
module tacho_multi
    import tacho_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int         NUM_CH    = 2,
    parameter int         CNT_W     = 12,
    parameter int         FILT_LEN  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        csr_a,
    input  logic [7:0]        csr_di,
    input  logic              csr_we,
    input  logic              csr_re,
    output logic [7:0]        csr_do,
    input  logic              ce_1s,
    input  logic [NUM_CH-1:0] tacho_in
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("tacho_multi: NUM_CH out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("tacho_multi: CNT_W out of range");
    end
    if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt_len
        $error("tacho_multi: FILT_LEN out of range");
    end
    if (int'(BASE_ADDR) + OFF_CNT_BASE + 2 * NUM_CH > ADDR_SPAN) begin : g_bad_base
        $error("tacho_multi: register map does not fit the address space");
    end

    reg_sel_t          sel;
    logic [7:0]        ctrl_q;
    logic [7:0]        status;
    logic              wr_ctrl, wr_status;
    logic [NUM_CH-1:0] lo_rd, ovf_clr, ovf, valid;
    logic [CNT_W-1:0]  capture [NUM_CH];
    logic [7:0]        shadow  [NUM_CH];

    assign sel       = decode(csr_a, BASE_ADDR, NUM_CH);
    assign wr_ctrl   = csr_we && (sel.kind == REG_CTRL);
    assign wr_status = csr_we && (sel.kind == REG_STATUS);

    // Non-existent channel bits are masked at write time so they read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= csr_di & ctrl_mask(NUM_CH);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign lo_rd[g]   = csr_re && (sel.kind == REG_CNT_LO) && (sel.ch == 2'(g));
        assign ovf_clr[g] = wr_status && csr_di[STATUS_OVF_LSB + g];

        tacho_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (ctrl_q[g]),
            .tacho_in (tacho_in[g]),
            .ce_1s    (ce_1s),
            .lo_rd    (lo_rd[g]),
            .ovf_clr  (ovf_clr[g]),
            .capture  (capture[g]),
            .shadow   (shadow[g]),
            .ovf      (ovf[g]),
            .valid    (valid[g])
        );
    end

    always_comb begin
        status = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            status[STATUS_OVF_LSB + n]   = ovf[n];
            status[STATUS_VALID_LSB + n] = valid[n];
        end
    end

    always_comb begin
        csr_do = '0;
        case (sel.kind)
            REG_CTRL:   csr_do = ctrl_q;
            REG_STATUS: csr_do = status;
            REG_CNT_LO: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (sel.ch == 2'(n)) csr_do = capture[n][7:0];
                end
            end
            REG_CNT_HI: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (sel.ch == 2'(n)) csr_do = shadow[n];
                end
            end
            default:    csr_do = '0;
        endcase
    end

endmodule

// File: tb/tb_tacho_multi.sv
// tb_tacho_multi -- scoreboard bench for tacho_multi.
// Two instances share the CSR bus and inputs: dut_a with default parameters
// and dut_b with CNT_W=9 for saturation. Each read pushes its expected value
// into a queue; a monitor pops and compares when it sees csr_re.
module tb_tacho_multi;
    import tacho_pkg::*;

    localparam logic [4:0] A_CTRL   = 5'(OFF_CTRL);
    localparam logic [4:0] A_STATUS = 5'(OFF_STATUS);
    localparam logic [4:0] A_LO0    = 5'(OFF_CNT_BASE);
    localparam logic [4:0] A_HI0    = 5'(OFF_CNT_BASE + 1);
    localparam logic [4:0] A_LO1    = 5'(OFF_CNT_BASE + 2);
    localparam logic [4:0] A_HI1    = 5'(OFF_CNT_BASE + 3);

    logic       clk, rst_n;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we, csr_re, ce_1s;
    logic [1:0] tacho;
    logic [7:0] do_a, do_b;

    typedef struct {
        string      name;
        logic [7:0] exp;
        bit         use_b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    tacho_multi dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .csr_a    (csr_a),
        .csr_di   (csr_di),
        .csr_we   (csr_we),
        .csr_re   (csr_re),
        .csr_do   (do_a),
        .ce_1s    (ce_1s),
        .tacho_in (tacho)
    );

    tacho_multi #(.CNT_W(9)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .csr_a    (csr_a),
        .csr_di   (csr_di),
        .csr_we   (csr_we),
        .csr_re   (csr_re),
        .csr_do   (do_b),
        .ce_1s    (ce_1s),
        .tacho_in (tacho)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 8'h%02h, expected 8'h%02h", nm, act, exp);
    endtask

    // Monitor: the read data is sampled on the falling edge, i.e. the value
    // presented before the rising edge that performs the read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (csr_re === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: addr %0d with empty scoreboard", csr_a);
                end else begin
                    e = sb.pop_front();
                    check(e.name, e.use_b ? do_b : do_a, e.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input bit use_b,
                      input string nm);
        exp_t e;
        e.name  = nm;
        e.exp   = exp;
        e.use_b = use_b;
        sb.push_back(e);
        csr_a  = a;
        csr_re = 1'b1;
        tick(1);
        csr_re = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        tick(1);
        csr_we = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tacho = 2'b11;
            tick(4);
            tacho = 2'b00;
            tick(4);
        end
    endtask

    task automatic gate();
        ce_1s = 1'b1;
        tick(1);
        ce_1s = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_n  = 1'b0;
        csr_a  = '0;
        csr_di = '0;
        csr_we = 1'b0;
        csr_re = 1'b0;
        ce_1s  = 1'b0;
        tacho  = 2'b00;
        tick(2);

        // Every address reads 0 while reset is held.
        for (int a = 0; a < 32; a++) rd(5'(a), 8'h00, 1'b0, "reset_read");
        rst_n = 1'b1;
        tick(2);
        rd(A_STATUS, 8'h00, 1'b0, "status_after_reset");

        // 250 clean pulses on ch0; unused CTRL bits must read back 0.
        wr(A_CTRL, 8'hFD);
        rd(A_CTRL, 8'h01, 1'b0, "ctrl_readback_masked");
        pulses(250);
        gate();
        rd(A_STATUS, 8'h10, 1'b0, "status_valid0");
        rd(A_LO0,    8'hFA, 1'b0, "cnt_lo0_250");
        rd(A_HI0,    8'h00, 1'b0, "cnt_hi0_250");
        rd(A_LO1,    8'h00, 1'b0, "cnt_lo1_disabled");
        rd(A_STATUS, 8'h00, 1'b0, "valid0_cleared_by_lo");

        // Glitch of 2 cycles is dropped; a 3-cycle pulse is counted exactly
        // 6 cycles after its rise. Gate on cycle 6 -> edge goes to the new
        // window; gate on cycle 7 -> edge is in the old window.
        tick(4);
        tacho = 2'b11; tick(2); tacho = 2'b00; tick(8);
        tacho = 2'b11; tick(3); tacho = 2'b00; tick(2);
        ce_1s = 1'b1; tick(1); ce_1s = 1'b0; tick(8);
        rd(A_STATUS, 8'h10, 1'b0, "status_after_glitch_window");
        rd(A_LO0,    8'h00, 1'b0, "glitch_and_boundary_edge");
        gate();
        rd(A_LO0,    8'h01, 1'b0, "boundary_edge_next_window");
        tacho = 2'b11; tick(3); tacho = 2'b00; tick(3);
        ce_1s = 1'b1; tick(1); ce_1s = 1'b0; tick(8);
        rd(A_LO0,    8'h01, 1'b0, "edge_before_cycle7_gate");

        // Edge coincident with the gate after 10 pulses.
        pulses(10);
        tacho = 2'b11; tick(4); tacho = 2'b00; tick(1);
        ce_1s = 1'b1; tick(1); ce_1s = 1'b0; tick(8);
        rd(A_LO0,    8'h0A, 1'b0, "coincident_old_window");
        pulses(3);
        gate();
        rd(A_LO0,    8'h04, 1'b0, "coincident_new_window");

        // Shadow coherency: capture 12'h345 then 12'h0AB.
        pulses(837);
        gate();
        rd(A_LO0,    8'h45, 1'b0, "cnt_lo0_345");
        rd(A_HI0,    8'h03, 1'b0, "cnt_hi0_345");
        rd(A_STATUS, 8'h00, 1'b0, "valid_cleared_after_lo");
        pulses(171);
        gate();
        rd(A_STATUS, 8'h10, 1'b0, "valid_set_again");
        rd(A_HI0,    8'h03, 1'b0, "shadow_held_across_gate");
        rd(A_LO0,    8'hAB, 1'b0, "cnt_lo0_0ab");
        rd(A_HI0,    8'h00, 1'b0, "cnt_hi0_0ab");

        // Saturation on the CNT_W=9 instance (already saturated above).
        rd(A_STATUS, 8'h01, 1'b1, "b_ovf_from_837");
        wr(A_STATUS, 8'hFF);
        rd(A_STATUS, 8'h00, 1'b1, "b_ovf_cleared");
        pulses(600);
        gate();
        rd(A_STATUS, 8'h11, 1'b1, "b_status_ovf_valid");
        rd(A_LO0,    8'hFF, 1'b1, "b_cnt_lo_sat");
        rd(A_HI0,    8'h01, 1'b1, "b_cnt_hi_sat");
        rd(A_LO0,    8'h58, 1'b0, "a_cnt_lo_600");
        rd(A_HI0,    8'h02, 1'b0, "a_cnt_hi_600");
        wr(A_STATUS, 8'h00);
        rd(A_STATUS, 8'h01, 1'b1, "b_ovf_write0_no_effect");
        wr(A_STATUS, 8'h01);
        rd(A_STATUS, 8'h00, 1'b1, "b_ovf_write1_clears");

        // One-cycle reset mid-window with 40 edges counted.
        pulses(40);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        rd(A_CTRL,   8'h00, 1'b0, "ctrl_after_midreset");
        rd(A_STATUS, 8'h00, 1'b0, "status_after_midreset");
        rd(A_LO0,    8'h00, 1'b0, "lo0_after_midreset");
        rd(A_HI0,    8'h00, 1'b0, "hi0_after_midreset");
        rd(A_LO1,    8'h00, 1'b0, "lo1_after_midreset");
        rd(A_HI1,    8'h00, 1'b0, "hi1_after_midreset");
        pulses(5);
        gate();
        rd(A_LO0,    8'h00, 1'b0, "no_count_until_enabled");
        rd(A_STATUS, 8'h00, 1'b0, "no_valid_while_disabled");
        wr(A_CTRL, 8'h01);
        pulses(7);
        gate();
        rd(A_STATUS, 8'h10, 1'b0, "valid0_only_after_enable");
        rd(A_LO0,    8'h07, 1'b0, "count_after_enable");
        rd(A_LO1,    8'h00, 1'b0, "ch1_disabled_throughout");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tacho_multi.md
TACHO_MULTI -- requirements
Module: tacho_multi

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 5'h0, first CSR address of the block.
REQ-002 SHALL have parameter NUM_CH, default 2, number of tacho channels (legal 1..4).
REQ-003 SHALL have parameter CNT_W, default 12, per-channel counter width (legal 9..16).
REQ-004 SHALL have parameter FILT_LEN, default 3, consecutive equal samples needed to accept a level change (legal 1..8).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port csr_a, input, 5, CSR byte address.
REQ-008 SHALL have port csr_di, input, 8, CSR write data.
REQ-009 SHALL have port csr_we, input, 1, write strobe, one cycle per write.
REQ-010 SHALL have port csr_re, input, 1, read strobe, one cycle per read access.
REQ-011 SHALL have port csr_do, output, 8, read data; combinational from csr_a; 8'h00 for unmapped addresses.
REQ-012 SHALL have port ce_1s, input, 1, one-cycle gate-window strobe.
REQ-013 SHALL have port tacho_in, input, NUM_CH, asynchronous tacho signals, bit n = channel n.

Function
REQ-014 Register map (offset from BASE_ADDR) SHALL be: 0 CTRL, 1 STATUS, 2+2n CNT_LO[n], 3+2n CNT_HI[n], n < NUM_CH.
REQ-015 CTRL[NUM_CH-1:0] SHALL be read/write channel enables; unused bits read 0, writes ignored.
REQ-016 Each channel SHALL pass tacho_in through a 2-flop synchroniser before filtering.
REQ-017 The filter SHALL change its output level only after FILT_LEN consecutive synchronised samples differ from the current filtered level; any mismatch breaks the run and restarts it.
REQ-018 A 0->1 transition of the filtered level SHALL be one counted edge; total latency from tacho_in to count increment 3+FILT_LEN cycles.
REQ-019 The live counter SHALL saturate at 2^CNT_W-1; a counted edge at saturation SHALL set the channel's sticky OVF bit.
REQ-020 On ce_1s the live counter SHALL copy into the capture register and restart; an edge on the same cycle SHALL count in the new window (live = 1).
REQ-021 On ce_1s the channel's VALID bit SHALL set if the channel is enabled.
REQ-022 STATUS[3:0] SHALL be OVF[n], STATUS[7:4] VALID[n]; bits for n >= NUM_CH read 0.
REQ-023 Writing 1 to a STATUS OVF bit SHALL clear it; same-cycle set wins over clear; writes of 0 have no effect; VALID is not writable.
REQ-024 CNT_LO[n] SHALL return capture[7:0]; a csr_re at that address SHALL latch capture[CNT_W-1:8] into a per-channel shadow and clear VALID[n] (same-cycle ce_1s set wins).
REQ-025 CNT_HI[n] SHALL return the shadow, zero-extended to 8 bits; reads of CNT_HI have no side effect.
REQ-026 A disabled channel SHALL hold filter level, filter run and live counter at 0, capture 0 on ce_1s, and not set VALID; OVF remains until cleared.
REQ-027 Enabling a channel mid-window SHALL start counting from 0 on the next cycle; the first capture is partial and still sets VALID.

Reset
REQ-028 On rst_n low, asynchronously: CTRL = 0, STATUS = 0, all synchronisers, filters, live counters, captures and shadows = 0; csr_do = 0 for every address.
REQ-029 Reset asserted mid-window SHALL discard the partial count; counting resumes only after a CTRL write enables channels.

Structure
REQ-030 Register offsets, STATUS bit positions and parameter legality limits SHALL live in a shared tacho package/header used by block and bench.
REQ-031 Per-channel logic (synchroniser, filter, counter, capture, shadow) SHALL be one sub-module, tacho_channel, instantiated NUM_CH times in a generate loop.
REQ-032 Out-of-range parameters SHALL be rejected at elaboration.

Verification
REQ-033 Defaults, CTRL=8'h01, 250 clean pulses on ch0 within one window, then ce_1s -> CNT_LO=8'hFA, CNT_HI=8'h00, STATUS=8'h10.
REQ-034 FILT_LEN=3, ch0 glitch of 2 cycles high -> no count; 3 cycles high -> count 1, increment 6 cycles after tacho_in rises.
REQ-035 CNT_W=9, 600 pulses in one window -> capture 511, CNT_LO=8'hFF, CNT_HI=8'h01, STATUS bit0=1; write STATUS=8'h01 -> bit0=0.
REQ-036 Edge coincident with ce_1s after 10 pulses -> capture 10, next window capture includes that edge (1 + subsequent).
REQ-037 Read CNT_LO (capture 12'h345), ce_1s with new capture 12'h0AB, then read CNT_HI -> 8'h03; VALID[0] set again by ce_1s.
REQ-038 rst_n low for one cycle mid-window with count 40 -> all registers 0; ch1 disabled throughout -> CNT_LO[1]=0, VALID[1]=0.
